// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU pipeline types: stage-register state and widths.
// Revision : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    localparam int PSR_OCC_W = 2;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_ONE   = 2'd1,
        PSR_FULL  = 2'd2
    } pstage_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic valid/ready pipeline stage register with flush-to-bubble.
//            Define PIPE_STAGE_REG_SKID_EN for the 2-entry skid variant with a
//            registered in_ready; otherwise a single register with
//            combinational in_ready.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [PSR_OCC_W-1:0] occupancy
);

    pstage_state_t    state;
    pstage_state_t    state_nxt;
    logic [WIDTH-1:0] main_reg;
    logic [WIDTH-1:0] main_nxt;
    logic             accept;
    logic             fire;

    // main_reg is kept at BUBBLE whenever the stage is empty, so it can drive
    // out_data directly without an output mux.
    assign out_valid = (state != PSR_EMPTY);
    assign out_data  = main_reg;
    assign occupancy = state;
    assign fire      = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

    logic [WIDTH-1:0] skid_reg;
    logic [WIDTH-1:0] skid_nxt;
    logic             ready_reg;

    assign in_ready = ready_reg;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_reg;
        skid_nxt  = skid_reg;
        if (flush) begin
            state_nxt = PSR_EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            case (state)
                PSR_EMPTY: begin
                    if (accept) begin
                        state_nxt = PSR_ONE;
                        main_nxt  = in_data;
                    end
                end
                PSR_ONE: begin
                    if (accept && fire) begin
                        main_nxt  = in_data;
                    end else if (accept) begin
                        state_nxt = PSR_FULL;
                        skid_nxt  = in_data;
                    end else if (fire) begin
                        state_nxt = PSR_EMPTY;
                        main_nxt  = BUBBLE;
                    end
                end
                PSR_FULL: begin
                    if (fire) begin
                        state_nxt = PSR_ONE;
                        main_nxt  = skid_reg;
                        skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    state_nxt = PSR_EMPTY;
                    main_nxt  = BUBBLE;
                    skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    // in_ready looks one cycle ahead so no path exists from out_ready.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= PSR_EMPTY;
            main_reg  <= BUBBLE;
            skid_reg  <= BUBBLE;
            ready_reg <= 1'b1;
        end else begin
            state     <= state_nxt;
            main_reg  <= main_nxt;
            skid_reg  <= skid_nxt;
            ready_reg <= (state_nxt != PSR_FULL);
        end
    end

`else

    assign in_ready = out_ready || !out_valid;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_reg;
        if (flush) begin
            state_nxt = PSR_EMPTY;
            main_nxt  = BUBBLE;
        end else if (accept) begin
            state_nxt = PSR_ONE;
            main_nxt  = in_data;
        end else if (fire) begin
            state_nxt = PSR_EMPTY;
            main_nxt  = BUBBLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= PSR_EMPTY;
            main_reg <= BUBBLE;
        end else begin
            state    <= state_nxt;
            main_reg <= main_nxt;
        end
    end

`endif

endmodule : pipe_stage_reg
`default_nettype wire
